match_event_logger: RTL and testbench

- Downstream consumer of the serial 1101 sequence detector; takes its match pulse `z` and shift-register snapshot `seq`.
- Timestamps each match and buffers timestamps in a small FIFO for a reader.
- Keeps a saturating match count and the gap between consecutive matches.
- Raises a threshold interrupt with an acknowledge handshake; flags detector/snapshot inconsistency.

---
 rtl/match_pkg.sv | 15 +
 rtl/ts_fifo.sv | 70 +++++++
 rtl/match_event_logger.sv | 141 ++++++++++++++
 tb/tb_match_event_logger.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// match_pkg
// Shared constants and types for the match event logger.
//   TARGET_PAT : pattern the upstream serial detector reports as a match
//   CNT_W_DEF  : default width of the match / since-ack counters
//   TS_W_DEF   : default width of timestamp and gap values
//   ts_t       : timestamp word at the default width
package match_pkg;

  localparam logic [3:0] TARGET_PAT = 4'b1101;
  localparam int         CNT_W_DEF  = 16;
  localparam int         TS_W_DEF   = 16;

  typedef logic [TS_W_DEF-1:0] ts_t;

endpackage

// File: rtl/ts_fifo.sv
// ts_fifo
// First-word-fall-through FIFO for timestamp words.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous flush (pointers, level and storage to zero)
//   push, din  : write request and data; ignored when full unless a pop
//                happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry, driven straight from storage
//   full/empty : status
//   level      : number of entries held
module ts_fifo #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [TS_W-1:0] din,
  output logic [TS_W-1:0] dout,
  output logic            full,
  output logic            empty,
  output logic [LW-1:0]   level
);

  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  assign do_pop  = pop & ~empty;
  // When full, a simultaneous pop frees the slot the write lands in
  // (wr_ptr == rd_ptr), so the push may proceed.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// match_event_logger
// Consumes the match pulse of a serial 1101 detector: timestamps matches
// into a FWFT FIFO, keeps a saturating match count and inter-match gap,
// raises a threshold interrupt with acknowledge, and flags matches whose
// shift-register snapshot disagrees with the target pattern.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   z, seq            : match pulse and detector snapshot
//   clear             : synchronous soft clear (wins over z and rd_en)
//   rd_en             : pop the head timestamp
//   rd_data, rd_valid : head timestamp and FIFO non-empty
//   fifo_level        : entries held
//   match_cnt         : saturating total match count
//   last_gap, gap_valid : cycles between the two most recent matches
//   overflow, seq_err : sticky error flags
//   irq, irq_ack      : level interrupt and its acknowledge
module match_event_logger
  import match_pkg::*;
#(
  parameter logic [3:0] TARGET     = TARGET_PAT,
  parameter int         CNT_W      = CNT_W_DEF,
  parameter int         TS_W       = TS_W_DEF,
  parameter int         DEPTH      = 4,
  parameter int         IRQ_THRESH = 8,
  localparam int        LW         = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z,
  input  logic [3:0]       seq,
  input  logic             clear,
  input  logic             rd_en,
  output logic [TS_W-1:0]  rd_data,
  output logic             rd_valid,
  output logic [LW-1:0]    fifo_level,
  output logic [CNT_W-1:0] match_cnt,
  output logic [TS_W-1:0]  last_gap,
  output logic             gap_valid,
  output logic             overflow,
  output logic             seq_err,
  output logic             irq,
  input  logic             irq_ack
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TS_W-1:0]  TS_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(IRQ_THRESH);

  logic [TS_W-1:0]  ts;
  logic [TS_W-1:0]  gap_cnt;
  logic             seen_first;
  logic [CNT_W-1:0] since_ack;
  logic [CNT_W-1:0] since_nxt;
  logic             match;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  assign match     = z & ~clear;
  assign pop       = rd_en & ~fifo_empty & ~clear;
  assign push      = match;
  assign rd_valid  = ~fifo_empty;
  assign since_nxt = (since_ack == CNT_MAX) ? since_ack : since_ack + 1'b1;

  ts_fifo #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (ts),
    .dout  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Free-running timestamp; only reset touches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts <= '0;
    else     ts <= ts + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt  <= '0;
      gap_cnt    <= '0;
      seen_first <= 1'b0;
      last_gap   <= '0;
      gap_valid  <= 1'b0;
      overflow   <= 1'b0;
      seq_err    <= 1'b0;
    end else if (clear) begin
      match_cnt  <= '0;
      gap_cnt    <= '0;
      seen_first <= 1'b0;
      last_gap   <= '0;
      gap_valid  <= 1'b0;
      overflow   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      if (match) begin
        if (match_cnt != CNT_MAX) match_cnt <= match_cnt + 1'b1;
        if (seen_first) begin
          last_gap  <= gap_cnt;
          gap_valid <= 1'b1;
        end
        seen_first <= 1'b1;
        gap_cnt    <= TS_W'(1);
        if (seq != TARGET) seq_err <= 1'b1;
        // A full FIFO only drops the entry when no pop frees a slot.
        if (fifo_full && !pop) overflow <= 1'b1;
      end else if (gap_cnt != TS_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // Acknowledge outranks a threshold crossing in the same cycle; the
  // coincident match still counts toward the next interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq       <= 1'b0;
      since_ack <= '0;
    end else if (clear) begin
      irq       <= 1'b0;
      since_ack <= '0;
    end else if (irq_ack) begin
      irq       <= 1'b0;
      since_ack <= match ? CNT_W'(1) : '0;
    end else if (match) begin
      since_ack <= since_nxt;
      if (since_nxt >= THRESH) irq <= 1'b1;
    end
  end

endmodule

// File: tb/tb_match_event_logger.sv
// tb_match_event_logger
// Directed stimulus against a queue-based behavioural model; a negedge
// process compares every output to the model each cycle, and literal
// expectations pin the model at key points.
module tb_match_event_logger;
  import match_pkg::*;

  localparam int CNT_W = 4;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;
  localparam int THR   = 8;
  localparam int LW    = 3;
  localparam int CMAX  = 15;
  localparam int TMAX  = 65535;

  logic             clk = 1'b0;
  logic             rst;
  logic             z;
  logic [3:0]       seq;
  logic             clear;
  logic             rd_en;
  logic             irq_ack;
  logic [TS_W-1:0]  rd_data;
  logic             rd_valid;
  logic [LW-1:0]    fifo_level;
  logic [CNT_W-1:0] match_cnt;
  logic [TS_W-1:0]  last_gap;
  logic             gap_valid;
  logic             overflow;
  logic             seq_err;
  logic             irq;

  match_event_logger #(
    .TARGET     (4'b1101),
    .CNT_W      (CNT_W),
    .TS_W       (TS_W),
    .DEPTH      (DEPTH),
    .IRQ_THRESH (THR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .z          (z),
    .seq        (seq),
    .clear      (clear),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_level (fifo_level),
    .match_cnt  (match_cnt),
    .last_gap   (last_gap),
    .gap_valid  (gap_valid),
    .overflow   (overflow),
    .seq_err    (seq_err),
    .irq        (irq),
    .irq_ack    (irq_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Behavioural model
  int  m_q[$];
  int  m_ts, m_cnt, m_gap, m_gv, m_gapc, m_have, m_ovf, m_serr, m_since, m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ts = 0; m_cnt = 0; m_gap = 0; m_gv = 0; m_gapc = 0; m_have = 0;
    m_ovf = 0; m_serr = 0; m_since = 0; m_irq = 0;
  endtask

  // One rising edge of the spec's behaviour, using the inputs held at it.
  task automatic model_clock();
    bit was_full, pop_ok;
    if (rst) return;
    if (clear) begin
      m_q.delete();
      m_cnt = 0; m_gap = 0; m_gv = 0; m_gapc = 0; m_have = 0;
      m_ovf = 0; m_serr = 0; m_since = 0; m_irq = 0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      pop_ok   = rd_en && (m_q.size() > 0);
      if (pop_ok) void'(m_q.pop_front());
      if (z) begin
        if (m_cnt < CMAX) m_cnt++;
        if (seq != 4'b1101) m_serr = 1;
        if (m_have) begin m_gap = m_gapc; m_gv = 1; end
        m_have = 1;
        m_gapc = 1;
        if (!was_full || pop_ok) m_q.push_back(m_ts);
        else m_ovf = 1;
      end else if (m_gapc < TMAX) begin
        m_gapc++;
      end
      if (irq_ack) begin
        m_irq = 0;
        m_since = z ? 1 : 0;
      end else if (z) begin
        if (m_since < CMAX) m_since++;
        if (m_since >= THR) m_irq = 1;
      end
    end
    m_ts = (m_ts + 1) % (TMAX + 1);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("match_cnt",  32'(match_cnt),  32'(m_cnt));
      chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      chk("rd_valid",   32'(rd_valid),   32'(m_q.size() > 0));
      if (m_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
      chk("last_gap",   32'(last_gap),   32'(m_gap));
      chk("gap_valid",  32'(gap_valid),  32'(m_gv));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("seq_err",    32'(seq_err),    32'(m_serr));
      chk("irq",        32'(irq),        32'(m_irq));
    end
  end

  task automatic step(input bit zz, input logic [3:0] ss, input bit rr,
                      input bit cc, input bit aa);
    z = zz; seq = ss; rd_en = rr; clear = cc; irq_ack = aa;
    @(posedge clk);
    model_clock();
    #2;
  endtask

  task automatic idle();
    step(1'b0, 4'b1101, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ts_t first_ts;
    int  t0;
    rst = 1'b1; z = 1'b0; seq = 4'b0000; clear = 1'b0; rd_en = 1'b0; irq_ack = 1'b0;
    model_reset();
    #2;
    chk_on = 1'b1;
    #20;
    chk("reset_cnt",   32'(match_cnt),  32'd0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_irq",   32'(irq),        32'd0);
    rst = 1'b0;

    // Matches at cycles 10, 13, 20
    for (int i = 0; i <= 20; i++)
      step(i == 10 || i == 13 || i == 20, 4'b1101, 1'b0, 1'b0, 1'b0);
    chk("t1_cnt",   32'(match_cnt),  32'd3);
    chk("t1_level", 32'(fifo_level), 32'd3);
    chk("t1_gap",   32'(last_gap),   32'd7);
    chk("t1_gv",    32'(gap_valid),  32'd1);
    chk("t1_serr",  32'(seq_err),    32'd0);
    chk("t1_head0", 32'(rd_data),    32'd10);
    step(1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    chk("t1_head1", 32'(rd_data),    32'd13);
    step(1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    chk("t1_head2", 32'(rd_data),    32'd20);
    step(1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);
    chk("t1_empty", 32'(rd_valid),   32'd0);
    step(1'b0, 4'b1101, 1'b1, 1'b0, 1'b0);   // pop on empty is ignored

    // Fill past DEPTH, then read+write on a full FIFO
    step(1'b0, 4'b1101, 1'b0, 1'b1, 1'b0);
    first_ts = ts_t'(m_ts);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
      idle(); idle();
    end
    chk("t2_level", 32'(fifo_level), 32'd4);
    chk("t2_ovf",   32'(overflow),   32'd1);
    chk("t2_cnt",   32'(match_cnt),  32'd5);
    chk("t2_head",  32'(rd_data),    32'(first_ts));
    step(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0);
    chk("t2_level_rw", 32'(fifo_level), 32'd4);
    chk("t2_ovf_rw",   32'(overflow),   32'd1);
    chk("t2_head_rw",  32'(rd_data),    32'(first_ts) + 32'd3);

    // Interrupt threshold and acknowledge
    step(1'b0, 4'b1101, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0);
      chk("t3_irq", 32'(irq), 32'(k >= 8));
      idle(); idle();
    end
    step(1'b1, 4'b1101, 1'b1, 1'b0, 1'b1);
    chk("t3_irq_ack", 32'(irq), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      idle(); idle();
      step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
      chk("t3_irq2", 32'(irq), 32'(k == 7));
    end

    // Snapshot mismatch
    step(1'b0, 4'b1101, 1'b0, 1'b1, 1'b0);
    idle(); idle();
    step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
    chk("t4_serr", 32'(seq_err),   32'd1);
    chk("t4_cnt",  32'(match_cnt), 32'd1);
    idle(); idle(); idle();
    step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
    chk("t4_serr_sticky", 32'(seq_err), 32'd1);

    // Clear with a coincident match
    idle(); idle();
    step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
    idle(); idle();
    t0 = m_ts;
    step(1'b1, 4'b1101, 1'b1, 1'b1, 1'b0);
    chk("t5_cnt",   32'(match_cnt),  32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_valid", 32'(rd_valid),   32'd0);
    chk("t5_serr",  32'(seq_err),    32'd0);
    chk("t5_gv",    32'(gap_valid),  32'd0);
    chk("t5_gap",   32'(last_gap),   32'd0);
    idle();
    step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
    chk("t5_ts_runs", 32'(rd_data), 32'(t0 + 2));

    // Asynchronous reset mid-stream
    step(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_rst_level", 32'(fifo_level), 32'd0);
    chk("t6_rst_valid", 32'(rd_valid),   32'd0);
    chk("t6_rst_cnt",   32'(match_cnt),  32'd0);
    chk("t6_rst_gv",    32'(gap_valid),  32'd0);
    idle();
    rst = 1'b0;

    // Counter saturation: 2^CNT_W + 2 matches
    for (int k = 0; k < 18; k++) step(1'b1, 4'b1101, 1'b1, 1'b0, 1'b0);
    chk("t6_sat_cnt", 32'(match_cnt), 32'd15);
    chk("t6_sat_irq", 32'(irq),       32'd1);
    idle(); idle();

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
